// File: rtl/sonic_dist_filter.sv
// ---------------------------------------------------------------------------
// sonic_dist_filter
//   Moving-average filter for ultrasonic distance samples (cm), followed by
//   a two-threshold hysteresis FSM that drives the obstacle flag consumed by
//   motion control. Out-of-range readings (0 or > MAX_CM) are clamped to
//   MAX_CM. The averaging buffer is preloaded with MAX_CM, so early averages
//   are biased toward "far".
//
//   Optional feature macro: DIST_WATCHDOG_EN
//     defined   : a silence watchdog raises stale after TIMEOUT_CYC cycles
//                 without dist_valid and forces the FSM to CLEAR.
//     undefined : no counter logic; stale is tied low.
//
// Ports
//   clk         in   1    system clock
//   rst         in   1    asynchronous, active-high reset
//   dist_in     in   DW   raw distance sample, cm
//   dist_valid  in   1    1-cycle strobe; dist_in valid this cycle
//   dist_avg    out  DW   registered moving average, cm
//   avg_valid   out  1    1-cycle pulse; dist_avg/obstacle just updated
//   obstacle    out  1    hysteresis obstacle flag (level)
//   stale       out  1    sensor silent for TIMEOUT_CYC cycles
//
// Pipeline: clamp (E0) -> buffer/sum update (E1) -> average + FSM (E2).
// AVG_LOG2 must be >= 1.
// ---------------------------------------------------------------------------
module sonic_dist_filter #(
  parameter int unsigned DW          = 20,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned MAX_CM      = 400,
  parameter int unsigned NEAR_CM     = 20,
  parameter int unsigned FAR_CM      = 25,
  parameter int unsigned TIMEOUT_CYC = 20_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dist_in,
  input  logic          dist_valid,
  output logic [DW-1:0] dist_avg,
  output logic          avg_valid,
  output logic          obstacle,
  output logic          stale
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = DW + AVG_LOG2;

  localparam logic [DW-1:0] MAX_V    = DW'(MAX_CM);
  localparam logic [DW-1:0] NEAR_V   = DW'(NEAR_CM);
  localparam logic [DW-1:0] FAR_V    = DW'(FAR_CM);
  localparam logic [SW-1:0] SUM_INIT = SW'(N * MAX_CM);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_NEAR  = 1'b1
  } state_t;

  // Stage 0: clamped sample
  logic [DW-1:0] s0_sample;
  logic          s0_valid;

  // Stage 1: circular buffer and running sum
  logic [DW-1:0]       dist_buf [N];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_next;
  logic                s1_valid;

  // Stage 2: average and FSM
  logic [DW-1:0] new_avg;
  state_t        state_q;
  state_t        state_d;
  logic          wd_fire;

  // ---------------------------------------------------------------- stage 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_sample <= MAX_V;
    end else begin
      s0_valid <= dist_valid;
      if (dist_valid) begin
        s0_sample <= (dist_in == '0 || dist_in > MAX_V) ? MAX_V : dist_in;
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  // The sum never goes negative: the value being removed is always part of
  // the current sum, and N*MAX_CM fits in DW+AVG_LOG2 bits.
  assign sum_next = sum_q + SW'(s0_sample) - SW'(dist_buf[wr_ptr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        dist_buf[i] <= MAX_V;
      end
      wr_ptr   <= '0;
      sum_q    <= SUM_INIT;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        sum_q            <= sum_next;
        dist_buf[wr_ptr] <= s0_sample;
        wr_ptr           <= wr_ptr + 1'b1;  // natural wrap modulo N
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  assign new_avg = DW'(sum_q >> AVG_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_avg  <= MAX_V;
      avg_valid <= 1'b0;
      state_q   <= ST_CLEAR;
    end else begin
      avg_valid <= s1_valid;
      state_q   <= state_d;
      if (s1_valid) begin
        dist_avg <= new_avg;
      end
    end
  end

  // The FSM looks at the average being registered this edge, so obstacle
  // changes on the same edge that raises avg_valid.
  always_comb begin
    state_d = state_q;
    if (wd_fire) begin
      state_d = ST_CLEAR;
    end else if (s1_valid) begin
      unique case (state_q)
        ST_CLEAR: if (new_avg < NEAR_V) state_d = ST_NEAR;
        ST_NEAR:  if (new_avg >= FAR_V) state_d = ST_CLEAR;
        default:  state_d = ST_CLEAR;
      endcase
    end
    obstacle = (state_q == ST_NEAR);
  end

  // --------------------------------------------------------------- watchdog
`ifdef DIST_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] WD_TERM = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] wd_cnt;
  logic          stale_q;

  // A strobe on the terminal cycle wins: the counter restarts instead.
  assign wd_fire = !dist_valid && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      stale_q <= 1'b0;
    end else if (dist_valid) begin
      wd_cnt  <= '0;
      stale_q <= 1'b0;
    end else begin
      if (wd_cnt != WD_TERM) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire) begin
        stale_q <= 1'b1;
      end
    end
  end

  assign stale = stale_q;
`else
  assign wd_fire = 1'b0;
  assign stale   = 1'b0;
`endif

endmodule
